sha1_wsched: RTL and testbench
==============================

Name: sha1_wsched

Overview:
- SHA-1 message-schedule stage, directly upstream of the round datapath; the round datapath's state registers consume W[t] each round.
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready input.
- Emits W[0..79] one word per accepted output beat, with the round index and a last flag.
- Expansion uses a 16-word sliding window: 16 registers, one XOR/rotate, no 80-word memory.

Parameters:
- ROUNDS, 80, number of schedule words emitted per block (reduced values used only in test).
- BLK_WORDS, 16, input words per block; fixed by SHA-1, not to be overridden.

Ports:
- clk, input, 1, rising-edge clock.
- r_n, input, 1, reset: one clock; reset is asynchronous and active-low.
- clr, input, 1, synchronous abort: returns to LOAD and discards the partial block/schedule.
- in_valid, input, 1, in_data holds a message word.
- in_ready, output, 1, block accepts a word this cycle.
- in_data, input, 32, message word, block order W[0] first.
- out_valid, output, 1, out_w/out_t are valid.
- out_ready, input, 1, downstream accepts the word.
- out_w, output, 32, schedule word W[t].
- out_t, output, 7, round index t (0..ROUNDS-1).
- out_last, output, 1, high with out_valid when t == ROUNDS-1.

Behaviour:
- Reset (r_n low, async): state = LOAD, load count = 0, t = 0, window = all zeros. Outputs: in_ready=0 during reset, out_valid=0, out_w=0, out_t=0, out_last=0.
- State LOAD:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready, in_data shifts into window slot 15 (window shifts toward slot 0); count increments.
  - On the 16th accepted word, go to RUN next cycle with t=0. No gap: out_valid=1 on the cycle after the 16th handshake.
- State RUN:
  - in_ready=0, out_valid=1.
  - out_w = window[0] (registered), out_t = t, out_last = (t == ROUNDS-1).
  - On out_ready: window shifts down one slot. slot 15 <= ROTL1(window[13] ^ window[8] ^ window[2] ^ window[0]), i.e. W[t+16]. t increments.
  - No advance without out_ready: out_w/out_t/out_last held stable, no combinational path from out_ready to out_w.
  - Handshake on t == ROUNDS-1: go to LOAD, count=0, t=0, out_valid=0 next cycle. Earliest new-block word accepted the following cycle, so the block-to-block bubble is exactly 1 cycle.
- Arithmetic: all XOR/rotate modulo 32 bits; ROTL1(x) = {x[30:0], x[31]}. Words 16..ROUNDS-1 computed; words 0..15 are input words unchanged.
- clr: highest synchronous priority, same effect as reset but synchronous. In LOAD, a word presented the same cycle as clr is dropped.
- in_valid during RUN: ignored (in_ready=0); the word is not lost upstream.
- out_ready during LOAD: ignored.
- Async reset mid-block: everything returns to reset values immediately; the partial block is lost.

Decomposition:
- Package sha1_pkg: SHA1_ROUNDS=80, SHA1_BLK_WORDS=16, word type (32-bit), round-index type (7-bit), state enum {LOAD, RUN}, rotl1 function.
- Sub-module sha1_wwin: 16x32 shift window with load/expand select and async clear. Top-level holds the FSM and counters.

Test Plan:
- Block "abc" (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 -> out_w: t=16 0xC2C4C700, t=17 0x00000000, t=18 0x00000030, t=19 0x85898E01. out_last only at t=79. Exactly 80 beats.
- Same block, out_ready toggled 1/0 randomly -> identical 80-word sequence. out_w/out_t stable while stalled. No duplicate or skipped t.
- Two back-to-back blocks with in_valid held high -> in_ready low during RUN. Second block's first word accepted exactly 1 cycle after the t=79 handshake. Second schedule correct.
- r_n asserted after 7 words loaded, then full "abc" block -> out_valid=0 immediately on reset. The new schedule matches the "abc" vector (stale words discarded).
- clr pulsed at t=40 in RUN -> out_valid=0 next cycle, in_ready=1, out_t=0. Next block schedules correctly from t=0.
- in_valid gaps of 3 cycles between words during LOAD -> RUN entered exactly 1 cycle after the 16th handshake; W values unchanged.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared types and helpers for the SHA-1 message-schedule block.
package sha1_pkg;

    localparam int unsigned SHA1_ROUNDS    = 80;
    localparam int unsigned SHA1_BLK_WORDS = 16;

    typedef logic [31:0] word_t;
    typedef logic [6:0]  rnd_t;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Rotate a 32-bit word left by one bit.
    function automatic word_t rotl1(input word_t x);
        return {x[30:0], x[31]};
    endfunction

endpackage

// File: rtl/sha1_wsched_if.sv
// Input word stream and output schedule stream of sha1_wsched.
interface sha1_wsched_if;

    logic              in_valid;
    logic              in_ready;
    sha1_pkg::word_t   in_data;
    logic              out_valid;
    logic              out_ready;
    sha1_pkg::word_t   out_w;
    sha1_pkg::rnd_t    out_t;
    logic              out_last;

    // Schedule block side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_w,
        output out_t,
        output out_last
    );

    // Message source / round datapath side.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_w,
        input  out_t,
        input  out_last
    );

endinterface

// File: rtl/sha1_wwin.sv
// 16-word sliding window: shifts in message words during load, and the
// expanded word W[t+16] during the run phase. Slot 0 always holds W[t].
module sha1_wwin
    import sha1_pkg::*;
(
    input  logic  clk,
    input  logic  r_n,
    input  logic  clr_i,
    input  logic  load_i,
    input  logic  expand_i,
    input  word_t data_i,
    output word_t w0_o
);

    word_t win_q [SHA1_BLK_WORDS];
    word_t win_d [SHA1_BLK_WORDS];
    word_t w_new;

    // Next window: clear, shift-in of a message word, or shift-in of W[t+16].
    always_comb begin
        // Slots 13/8/2/0 hold W[t+13], W[t+8], W[t+2], W[t].
        w_new = rotl1(win_q[13] ^ win_q[8] ^ win_q[2] ^ win_q[0]);
        win_d = win_q;
        if (clr_i) begin
            for (int i = 0; i < SHA1_BLK_WORDS; i++) begin
                win_d[i] = '0;
            end
        end else if (load_i || expand_i) begin
            for (int i = 0; i < SHA1_BLK_WORDS - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[SHA1_BLK_WORDS-1] = load_i ? data_i : w_new;
        end
    end

    // Window registers with asynchronous clear.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            for (int i = 0; i < SHA1_BLK_WORDS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SHA1_BLK_WORDS; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign w0_o = win_q[0];

endmodule

// File: rtl/sha1_wsched.sv
// SHA-1 message schedule: loads 16 words, then emits W[0..ROUNDS-1] one word
// per output handshake. Holds the LOAD/RUN FSM and the load/round counters.
module sha1_wsched
    import sha1_pkg::*;
#(
    parameter int unsigned ROUNDS    = SHA1_ROUNDS,
    parameter int unsigned BLK_WORDS = SHA1_BLK_WORDS
) (
    input  logic          clk,
    input  logic          r_n,
    input  logic          clr,
    sha1_wsched_if.slave  bus
);

    localparam rnd_t       LastT   = rnd_t'(ROUNDS - 1);
    localparam logic [3:0] LastCnt = 4'(BLK_WORDS - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    rnd_t       t_q, t_d;
    logic       load, expand;
    logic       in_rdy, out_vld;
    logic       in_hs, out_hs;
    word_t      w0;

    // in_ready is also forced low while reset is held.
    assign in_rdy  = (state_q == LOAD) && r_n;
    assign out_vld = (state_q == RUN);
    assign in_hs   = bus.in_valid && in_rdy;
    assign out_hs  = out_vld && bus.out_ready;

    // Next-state, counters and window control; clr overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        load    = 1'b0;
        expand  = 1'b0;
        if (clr) begin
            state_d = LOAD;
            cnt_d   = '0;
            t_d     = '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (in_hs) begin
                        load = 1'b1;
                        if (cnt_q == LastCnt) begin
                            state_d = RUN;
                            cnt_d   = '0;
                            t_d     = '0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                RUN: begin
                    if (out_hs) begin
                        expand = 1'b1;
                        if (t_q == LastT) begin
                            state_d = LOAD;
                            t_d     = '0;
                        end else begin
                            t_d = t_q + rnd_t'(1);
                        end
                    end
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
        end
    end

    sha1_wwin u_wwin (
        .clk      (clk),
        .r_n      (r_n),
        .clr_i    (clr),
        .load_i   (load),
        .expand_i (expand),
        .data_i   (bus.in_data),
        .w0_o     (w0)
    );

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_w     = w0;
    assign bus.out_t     = t_q;
    assign bus.out_last  = out_vld && (t_q == LastT);

    // A stalled output word must not move.
    a_stall_stable : assert property (@(posedge clk) disable iff (!r_n)
        (out_vld && !bus.out_ready && !clr) |=> ($stable(bus.out_w) && $stable(bus.out_t)));

endmodule

// File: tb/tb_sha1_wsched.sv
// Scoreboard bench for sha1_wsched: stimulus pushes expected schedule words,
// a negedge monitor pops and compares on every output handshake.
module tb_sha1_wsched;
    import sha1_pkg::*;

    localparam int unsigned NR = 80;

    typedef struct packed {
        logic [31:0] w;
        logic [6:0]  t;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic r_n = 1'b0;
    logic clr = 1'b0;

    sha1_wsched_if bus ();

    sha1_wsched #(
        .ROUNDS    (NR),
        .BLK_WORDS (16)
    ) dut (
        .clk (clk),
        .r_n (r_n),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          rmode    = 1'b0;
    bit          abc_chk  = 1'b0;
    bit          b2b_chk  = 1'b0;
    bit          pend_first = 1'b0;
    int          in_hs_cyc  = 0;
    int          last_hs_cyc = 0;
    int          beats    = 0;
    bit          prev_stall = 1'b0;
    bit          prev_vld   = 1'b0;
    logic [31:0] sv_w;
    logic [6:0]  sv_t;
    logic [31:0] abc_blk [16];
    logic [31:0] blk2    [16];
    logic [31:0] abc_h   [4] = '{32'hC2C4C700, 32'h00000000, 32'h00000030, 32'h85898E01};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0d)", name, act, req, cyc);
        end
    endtask

    // Reference schedule using the textbook recurrence over the full 80 words.
    function automatic void push_exp(input logic [31:0] b [16]);
        logic [31:0] w [NR];
        exp_t e;
        for (int t = 0; t < NR; t++) begin
            if (t < 16) w[t] = b[t];
            else        w[t] = rotl1(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16]);
            e.w    = w[t];
            e.t    = 7'(t);
            e.last = (t == NR - 1);
            q.push_back(e);
        end
    endfunction

    initial forever @(posedge clk) cyc++;

    // Downstream ready: constant 1 or random toggling.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus.out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        @(negedge clk);
        if (!r_n) begin
            prev_stall = 1'b0;
            prev_vld   = 1'b0;
            beats      = 0;
        end else begin
            if (bus.out_valid && bus.in_ready) chk("in_ready_in_run", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid && !prev_vld) chk("run_entry_lat", 64'(cyc - in_hs_cyc), 64'd1);
            if (prev_stall && bus.out_valid) begin
                chk("stall_w", 64'(bus.out_w), 64'(sv_w));
                chk("stall_t", 64'(bus.out_t), 64'(sv_t));
            end
            if (bus.in_valid && bus.in_ready) begin
                if (pend_first) begin
                    chk("b2b_bubble", 64'(cyc - last_hs_cyc), 64'd1);
                    pend_first = 1'b0;
                end
                in_hs_cyc = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'(bus.out_t), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_w", 64'(bus.out_w), 64'(e.w));
                    chk("out_t", 64'(bus.out_t), 64'(e.t));
                    chk("out_last", 64'(bus.out_last), 64'(e.last));
                    if (abc_chk && bus.out_t >= 7'd16 && bus.out_t <= 7'd19)
                        chk("abc_hand", 64'(bus.out_w), 64'(abc_h[bus.out_t - 7'd16]));
                end
                beats++;
                if (bus.out_last) begin
                    chk("beat_count", 64'(beats), 64'(NR));
                    beats       = 0;
                    last_hs_cyc = cyc;
                    pend_first  = b2b_chk;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_vld   = bus.out_valid;
            sv_w       = bus.out_w;
            sv_t       = bus.out_t;
        end
    end

    // Send n words of a block with 'gap' idle cycles between them.
    task automatic send(input logic [31:0] b [16], input int n, input int gap, input bit hold);
        int bnd;
        if (n == 16) push_exp(b);
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && i > 0) begin
                bus.in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = b[i];
            bnd = 0;
            forever begin
                @(negedge clk);
                if (bus.in_ready) break;
                bnd++;
                if (bnd > 3000) begin
                    $display("FAIL in_ready_timeout actual=0 required=1");
                    $fatal(1, "input handshake never completed");
                end
            end
            @(posedge clk);
            #1;
        end
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int bnd = 0;
        while (q.size() != 0 && bnd < 5000) begin
            @(negedge clk);
            bnd++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_t(input logic [6:0] tt);
        int bnd = 0;
        do begin
            @(negedge clk);
            bnd++;
        end while (!(bus.out_valid && bus.out_t == tt) && bnd < 2000);
        chk("wait_t_reached", 64'(bus.out_t), 64'(tt));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            abc_blk[i] = 32'h0;
            blk2[i]    = 32'hDEADBEEF ^ (32'h01010101 * i);
        end
        abc_blk[0]  = 32'h61626380;
        abc_blk[15] = 32'h00000018;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_w", 64'(bus.out_w), 64'd0);
        chk("rst_out_t", 64'(bus.out_t), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        r_n = 1'b1;
        @(posedge clk);
        #1;

        // "abc" with ready held high.
        abc_chk = 1'b1;
        send(abc_blk, 16, 0, 1'b0);
        drain();

        // Same block with random stalls.
        rmode = 1'b1;
        send(abc_blk, 16, 0, 1'b0);
        drain();

        // Back-to-back blocks, in_valid held high.
        abc_chk = 1'b0;
        b2b_chk = 1'b1;
        send(abc_blk, 16, 0, 1'b1);
        send(blk2, 16, 0, 1'b0);
        drain();
        b2b_chk = 1'b0;
        pend_first = 1'b0;
        rmode = 1'b0;

        // Reset after 7 words, then a full block.
        send(blk2, 7, 0, 1'b0);
        r_n = 1'b0;
        #1;
        chk("rst7_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst7_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 r_n = 1'b1;
        abc_chk = 1'b1;
        send(abc_blk, 16, 0, 1'b0);
        drain();

        // Async reset in the middle of a schedule.
        send(blk2, 16, 0, 1'b0);
        abc_chk = 1'b0;
        wait_t(7'd30);
        r_n = 1'b0;
        #1;
        chk("rst_run_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_run_out_t", 64'(bus.out_t), 64'd0);
        q.delete();
        @(posedge clk);
        #1 r_n = 1'b1;

        // clr at t=40.
        abc_chk = 1'b1;
        send(abc_blk, 16, 0, 1'b0);
        wait_t(7'd40);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        q.delete();
        beats = 0;
        @(negedge clk);
        chk("clr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("clr_in_ready", 64'(bus.in_ready), 64'd1);
        chk("clr_out_t", 64'(bus.out_t), 64'd0);
        @(posedge clk);
        #1;
        send(abc_blk, 16, 0, 1'b0);
        drain();

        // Gaps of 3 idle cycles between input words.
        abc_chk = 1'b0;
        send(blk2, 16, 3, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
